time_set_controller: RTL and testbench
======================================

// Module: time_set_controller
// PURPOSE
//  User-facing writer for the system counter's load interface. Turns debounced push-button levels
//  into an hour/minute edit sequence seeded from the running BCD time, then drives time_hours,
//  time_minutes and a held load strobe into the counter. Sits between the button debouncers and
//  the system counter; also exposes edit status to the display driver for digit blinking.
// PARAMETERS
//  HOLD_CYCLES    50_000_000  cycles a button stays high after its rising edge before auto-repeat starts
//  REPEAT_CYCLES  10_000_000  cycles between auto-repeat steps while the button stays held
//  TIMEOUT_CYCLES 500_000_000 idle cycles in an edit state before abandoning the edit (no load)
//  LOAD_HOLD      50_000_000  cycles load stays high in COMMIT (>= one consumer sampling period)
// PORTS
//  clk            in   1  system clock; all state updates on posedge
//  reset          in   1  asynchronous, active-low reset
//  btn_center     in   1  debounced level: enter edit / advance field / commit
//  btn_up         in   1  debounced level: increment current field
//  btn_down       in   1  debounced level: decrement current field
//  cur_hour_tens  in   3  running time, BCD hour tens (0-2)
//  cur_hour_units in   4  running time, BCD hour units (0-9)
//  cur_min_tens   in   3  running time, BCD minute tens (0-5)
//  cur_min_units  in   4  running time, BCD minute units (0-9)
//  time_hours     out  5  binary hour to load, 0-23
//  time_minutes   out  6  binary minute to load, 0-59
//  load           out  1  load strobe to counter, high for exactly LOAD_HOLD cycles per commit
//  setting        out  1  high in EDIT_HOUR, EDIT_MIN and COMMIT
//  edit_field     out  2  00 none, 01 hours, 10 minutes (display blink select)
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE; time_hours=0, time_minutes=0, load=0, setting=0,
//    edit_field=00; all timers and edge-detect history cleared (history = 0).
//  - Edge detect: rising edge = level 1 now, 0 on previous clk. Outside edit states only
//    btn_center edges act; up/down are ignored.
//  - FSM states: IDLE, EDIT_HOUR, EDIT_MIN, COMMIT.
//    IDLE + center edge -> EDIT_HOUR; the same cycle captures hours = tens*10 + units and
//      minutes = tens*10 + units from the cur_* inputs (out-of-range BCD clamped to 23 / 59).
//    EDIT_HOUR + center edge -> EDIT_MIN.  EDIT_MIN + center edge -> COMMIT.
//    COMMIT: load=1 for LOAD_HOLD cycles, then -> IDLE with load=0. Buttons ignored in COMMIT.
//    EDIT_* with no button edge or repeat step for TIMEOUT_CYCLES -> IDLE, load never asserted;
//      time_hours/time_minutes keep the abandoned edit values.
//  - Step: an up edge adds 1 to the active field; a down edge subtracts 1. Values wrap modulo
//    24 (hours) / 60 (minutes): 23+1=0, 0-1=23, 59+1=0, 0-1=59. Minute wrap never carries into hours.
//  - Auto-repeat: a button held continuously for HOLD_CYCLES after its edge produces one step,
//    then one more step every REPEAT_CYCLES until released. Release clears the repeat timer.
//  - Simultaneous events: center edge together with up/down -> field advance only, no step.
//    Up and down both active in the same cycle (edge or repeat) -> no step; repeat timers reset.
//  - Any step or center edge reloads the timeout counter.
//  - Outputs are registered. time_hours and time_minutes are stable for the whole load window and
//    in IDLE hold the last committed or abandoned values.
//  - setting = (state != IDLE). edit_field = 01 in EDIT_HOUR, 10 in EDIT_MIN, else 00.
//  - Reset during COMMIT drops load asynchronously and returns to IDLE; no partial load is retried.
// TESTING (bench uses HOLD=4, REPEAT=2, TIMEOUT=20, LOAD_HOLD=3)
//  1. cur=13:47, center pulse -> setting=1, edit_field=01, time_hours=13, time_minutes=47 next cycle.
//  2. Hours=23, up pulse -> 0; then down pulse -> 23. Minutes=59, up -> 0 with hours unchanged.
//  3. Seed 08:15, up x2 in hours, center, down x1 in minutes, center -> load high exactly 3 cycles
//     with 10:14 stable throughout, then IDLE, setting=0.
//  4. Hold btn_up 10 cycles in EDIT_MIN from 00 -> steps on edge, edge+4, +6, +8 -> minutes=04.
//  5. Enter edit, no buttons for 20 cycles -> IDLE, load never asserted, edit_field=00.
//  6. Assert reset (low) on the second cycle of COMMIT -> load=0 immediately, all outputs zero;
//     up+down same-cycle edges in EDIT_HOUR -> value unchanged.

Source files
------------

// File: rtl/time_set_controller.sv
// Push-button time editor: seeds hour/minute from the running BCD clock, steps them with
// auto-repeat, and drives a held load strobe into the system counter on commit.
module time_set_controller #(
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned REPEAT_CYCLES  = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned LOAD_HOLD      = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_center,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [2:0] cur_hour_tens,
  input  logic [3:0] cur_hour_units,
  input  logic [2:0] cur_min_tens,
  input  logic [3:0] cur_min_units,
  output logic [4:0] time_hours,
  output logic [5:0] time_minutes,
  output logic       load,
  output logic       setting,
  output logic [1:0] edit_field
);

  localparam int unsigned RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam int unsigned TMAX = (TIMEOUT_CYCLES > LOAD_HOLD) ? TIMEOUT_CYCLES : LOAD_HOLD;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [RW-1:0] HOLD_C  = RW'(HOLD_CYCLES);
  localparam logic [RW-1:0] REP_C   = RW'(REPEAT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] LD_LAST = TW'(LOAD_HOLD - 1);

  typedef enum logic [1:0] {IDLE, EDIT_HOUR, EDIT_MIN, COMMIT} state_t;

  state_t        state_q, state_d;
  logic          center_prev_q, up_prev_q, down_prev_q;
  logic [RW-1:0] rcnt_q [2];
  logic [RW-1:0] rcnt_d [2];
  logic          rph_q  [2];
  logic          rph_d  [2];
  logic [TW-1:0] tmr_q, tmr_d;
  logic [4:0]    hours_q, hours_d;
  logic [5:0]    minutes_q, minutes_d;
  logic          load_q, load_d;
  logic          setting_q, setting_d;
  logic [1:0]    field_q, field_d;

  logic       c_edge;
  logic [1:0] lvl, edge_v, rep;
  logic       up_evt, dn_evt, step_up, step_dn, activity, in_edit;
  logic [6:0] hsum, msum;

  always_comb begin
    c_edge  = btn_center & ~center_prev_q;
    lvl     = {btn_down, btn_up};
    edge_v  = {btn_down & ~down_prev_q, btn_up & ~up_prev_q};
    in_edit = (state_q == EDIT_HOUR) || (state_q == EDIT_MIN);
    rep     = '0;

    // Per-button repeat timer: first target HOLD after the edge, then REPEAT between steps.
    for (int unsigned i = 0; i < 2; i++) begin
      rcnt_d[i] = rcnt_q[i];
      rph_d[i]  = rph_q[i];
      if (!in_edit || !lvl[i]) begin
        rcnt_d[i] = '0;
        rph_d[i]  = 1'b0;
      end else if (edge_v[i]) begin
        rcnt_d[i] = RW'(1);
        rph_d[i]  = 1'b0;
      end else if (rcnt_q[i] == (rph_q[i] ? REP_C : HOLD_C)) begin
        rep[i]    = 1'b1;
        rcnt_d[i] = RW'(1);
        rph_d[i]  = 1'b1;
      end else begin
        rcnt_d[i] = rcnt_q[i] + RW'(1);
      end
    end

    up_evt = edge_v[0] | rep[0];
    dn_evt = edge_v[1] | rep[1];
    if (up_evt && dn_evt) begin
      for (int unsigned i = 0; i < 2; i++) begin
        rcnt_d[i] = '0;
        rph_d[i]  = 1'b0;
      end
    end
    step_up  = in_edit & up_evt & ~dn_evt & ~c_edge;
    step_dn  = in_edit & dn_evt & ~up_evt & ~c_edge;
    activity = c_edge | (|edge_v) | (|rep);

    hsum = 7'(cur_hour_tens) * 7'd10 + 7'(cur_hour_units);
    msum = 7'(cur_min_tens) * 7'd10 + 7'(cur_min_units);

    state_d   = state_q;
    tmr_d     = tmr_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    load_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (c_edge) begin
          state_d   = EDIT_HOUR;
          tmr_d     = '0;
          hours_d   = (hsum > 7'd23) ? 5'd23 : hsum[4:0];
          minutes_d = (msum > 7'd59) ? 6'd59 : msum[5:0];
        end
      end
      EDIT_HOUR, EDIT_MIN: begin
        if (c_edge) begin
          state_d = (state_q == EDIT_HOUR) ? EDIT_MIN : COMMIT;
          load_d  = (state_q == EDIT_MIN);
          tmr_d   = '0;
        end else if (activity) begin
          tmr_d = '0;
          if (state_q == EDIT_HOUR) begin
            if (step_up)      hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
            else if (step_dn) hours_d = (hours_q == 5'd0) ? 5'd23 : hours_q - 5'd1;
          end else begin
            if (step_up)      minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
            else if (step_dn) minutes_d = (minutes_q == 6'd0) ? 6'd59 : minutes_q - 6'd1;
          end
        end else if (tmr_q == TO_LAST) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      COMMIT: begin
        if (tmr_q == LD_LAST) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else begin
          load_d = 1'b1;
          tmr_d  = tmr_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    setting_d = (state_d != IDLE);
    field_d   = (state_d == EDIT_HOUR) ? 2'b01 : (state_d == EDIT_MIN) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      center_prev_q <= 1'b0;
      up_prev_q     <= 1'b0;
      down_prev_q   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        rcnt_q[i] <= '0;
        rph_q[i]  <= 1'b0;
      end
      tmr_q     <= '0;
      hours_q   <= '0;
      minutes_q <= '0;
      load_q    <= 1'b0;
      setting_q <= 1'b0;
      field_q   <= '0;
    end else begin
      state_q       <= state_d;
      center_prev_q <= btn_center;
      up_prev_q     <= btn_up;
      down_prev_q   <= btn_down;
      for (int unsigned i = 0; i < 2; i++) begin
        rcnt_q[i] <= rcnt_d[i];
        rph_q[i]  <= rph_d[i];
      end
      tmr_q     <= tmr_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      load_q    <= load_d;
      setting_q <= setting_d;
      field_q   <= field_d;
    end
  end

  assign time_hours   = hours_q;
  assign time_minutes = minutes_q;
  assign load         = load_q;
  assign setting      = setting_q;
  assign edit_field   = field_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with shortened timing parameters.
module tb_time_set_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_center, btn_up, btn_down;
  logic [2:0] cur_hour_tens, cur_min_tens;
  logic [3:0] cur_hour_units, cur_min_units;
  logic [4:0] time_hours;
  logic [5:0] time_minutes;
  logic       load, setting;
  logic [1:0] edit_field;

  int n_total = 0;
  int n_bad   = 0;

  time_set_controller #(
    .HOLD_CYCLES   (4),
    .REPEAT_CYCLES (2),
    .TIMEOUT_CYCLES(20),
    .LOAD_HOLD     (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_center    (btn_center),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .cur_hour_tens (cur_hour_tens),
    .cur_hour_units(cur_hour_units),
    .cur_min_tens  (cur_min_tens),
    .cur_min_units (cur_min_units),
    .time_hours    (time_hours),
    .time_minutes  (time_minutes),
    .load          (load),
    .setting       (setting),
    .edit_field    (edit_field)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0 = center, 1 = up, 2 = down; one-cycle high pulse then one low cycle
  task automatic pulse(input int b);
    case (b)
      0: btn_center = 1'b1;
      1: btn_up     = 1'b1;
      default: btn_down = 1'b1;
    endcase
    tick();
    btn_center = 1'b0;
    btn_up     = 1'b0;
    btn_down   = 1'b0;
    tick();
  endtask

  task automatic set_cur(input int ht, input int hu, input int mt, input int mu);
    cur_hour_tens  = 3'(ht);
    cur_hour_units = 4'(hu);
    cur_min_tens   = 3'(mt);
    cur_min_units  = 4'(mu);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    logic saw_load;
    n = 0;
    saw_load = 1'b0;
    while (setting === 1'b1 && n < 40) begin
      tick();
      if (load === 1'b1) saw_load = 1'b1;
      n++;
    end
    check({tag, "_idle"}, setting, 0);
    check({tag, "_noload"}, saw_load, 0);
  endtask

  initial begin
    int exp_min [10];
    exp_min = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};
    reset = 1'b0;
    btn_center = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    set_cur(1, 3, 4, 7);
    tick();
    tick();
    check("rst_hours", time_hours, 0);
    check("rst_minutes", time_minutes, 0);
    check("rst_load", load, 0);
    check("rst_setting", setting, 0);
    check("rst_field", edit_field, 0);
    reset = 1'b1;
    tick();

    // up/down outside edit are ignored
    pulse(1);
    check("idle_up_ignored", setting, 0);

    // seed 13:47
    btn_center = 1'b1;
    tick();
    check("seed_setting", setting, 1);
    check("seed_field", edit_field, 1);
    check("seed_hours", time_hours, 13);
    check("seed_minutes", time_minutes, 47);
    btn_center = 1'b0;
    tick();

    // hour wrap
    for (int i = 0; i < 10; i++) pulse(1);
    check("hours_to_23", time_hours, 23);
    pulse(1);
    check("hours_wrap_up", time_hours, 0);
    pulse(2);
    check("hours_wrap_down", time_hours, 23);
    pulse(0);
    check("field_min", edit_field, 2);
    for (int i = 0; i < 12; i++) pulse(1);
    check("min_to_59", time_minutes, 59);
    pulse(1);
    check("min_wrap_up", time_minutes, 0);
    check("min_no_carry", time_hours, 23);
    pulse(2);
    check("min_wrap_down", time_minutes, 59);
    pulse(1);
    pulse(0);
    check("commit_a_field", edit_field, 0);
    for (int i = 0; i < 6; i++) tick();
    check("commit_a_idle", setting, 0);
    check("commit_a_hours", time_hours, 23);
    check("commit_a_minutes", time_minutes, 0);

    // full edit 08:15 -> 10:14 with timed load window
    set_cur(0, 8, 1, 5);
    pulse(0);
    check("b_seed_hours", time_hours, 8);
    pulse(1);
    pulse(1);
    pulse(0);
    pulse(2);
    btn_center = 1'b1;
    tick();
    btn_center = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("b_load%0d", k), load, 1);
      check($sformatf("b_hours%0d", k), time_hours, 10);
      check($sformatf("b_minutes%0d", k), time_minutes, 14);
      tick();
    end
    check("b_load_end", load, 0);
    check("b_setting_end", setting, 0);

    // auto-repeat in minutes from 00
    set_cur(0, 0, 0, 0);
    pulse(0);
    pulse(0);
    check("rep_start", time_minutes, 0);
    btn_up = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("rep_k%0d", k), time_minutes, exp_min[k]);
    end
    btn_up = 1'b0;
    tick();
    check("rep_release", time_minutes, 4);
    wait_idle("rep");

    // clamped seed, then abandon by timeout
    set_cur(2, 9, 7, 9);
    btn_center = 1'b1;
    tick();
    btn_center = 1'b0;
    check("clamp_hours", time_hours, 23);
    check("clamp_minutes", time_minutes, 59);
    for (int k = 1; k < 20; k++) begin
      tick();
      if (setting !== 1'b1 || load !== 1'b0) check($sformatf("to_early%0d", k), {setting, load}, 2);
    end
    check("to_before", setting, 1);
    tick();
    check("to_setting", setting, 0);
    check("to_field", edit_field, 0);
    check("to_load", load, 0);
    check("to_keep_hours", time_hours, 23);

    // up+down together, then reset during commit
    set_cur(1, 2, 3, 4);
    pulse(0);
    btn_up = 1'b1;
    btn_down = 1'b1;
    tick();
    check("both_hours", time_hours, 12);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick();
    check("both_hours_after", time_hours, 12);
    pulse(0);
    btn_center = 1'b1;
    tick();
    btn_center = 1'b0;
    check("r_load1", load, 1);
    tick();
    check("r_load2", load, 1);
    reset = 1'b0;
    #1;
    check("r_load_drop", load, 0);
    check("r_hours", time_hours, 0);
    check("r_minutes", time_minutes, 0);
    check("r_setting", setting, 0);
    check("r_field", edit_field, 0);
    tick();
    reset = 1'b1;
    tick();
    check("r_stay_idle", {setting, load}, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
